// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - N-port arbiter owning the memory_unit handshake
// Round-robin or fixed priority, forced-select override and a sticky hang watchdog.
module memory_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int RR_MODE    = 1,
  parameter int TIMEOUT    = 1023
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            port_req,
  input  logic [2*NUM_PORTS-1:0]          port_func,
  input  logic [ADDR_WIDTH*NUM_PORTS-1:0] port_address,
  input  logic [DATA_WIDTH*NUM_PORTS-1:0] port_write_data,
  input  logic                            force_en,
  input  logic [$clog2(NUM_PORTS)-1:0]    force_sel,
  output logic [NUM_PORTS-1:0]            port_grant,
  output logic [NUM_PORTS-1:0]            port_done,
  output logic [DATA_WIDTH-1:0]           port_read_data,
  output logic [1:0]                      mem_func,
  output logic                            mem_execute,
  output logic [ADDR_WIDTH-1:0]           mem_address,
  output logic [DATA_WIDTH-1:0]           mem_write_data,
  input  logic                            mem_ready,
  input  logic [DATA_WIDTH-1:0]           read_data,
  output logic                            timeout
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = ($clog2(TIMEOUT + 1) > 2) ? $clog2(TIMEOUT + 1) : 2;
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
  localparam logic [PW:0]   NP      = (PW+1)'(NUM_PORTS);

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_BUSY, S_DONE} state_t;

  state_t                state, state_nx;
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         owner;
  logic [NUM_PORTS-1:0]  owner_oh;
  logic [CW-1:0]         wd_cnt;
  logic                  wd_hit;
  logic                  wd_fire;
  logic [NUM_PORTS-1:0]  eligible;
  logic [PW:0]           cand;
  logic [PW-1:0]         win;
  logic                  win_valid;
  logic [1:0]            sel_func;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // A force_sel beyond NUM_PORTS matches no port, so nothing is eligible.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!force_en || force_sel == PW'(i)) eligible[i] = port_req[i];
    end
  end

  always_comb begin
    win       = '0;
    win_valid = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = (RR_MODE != 0) ? {1'b0, rr_ptr} + (PW+1)'(k) : (PW+1)'(k);
      if (cand >= NP) cand = cand - NP;
      if (!win_valid && eligible[cand[PW-1:0]]) begin
        win_valid = 1'b1;
        win       = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    sel_func  = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (win == PW'(i)) begin
        sel_func  = port_func[2*i +: 2];
        sel_addr  = port_address[ADDR_WIDTH*i +: ADDR_WIDTH];
        sel_wdata = port_write_data[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  assign wd_hit = (TIMEOUT != 0) && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Ready still high two cycles after execute means memory finished without dropping is_ready.
  always_comb begin
    state_nx = state;
    wd_fire  = 1'b0;
    case (state)
      S_IDLE: if (mem_ready && win_valid) state_nx = S_ACCEPT;
      S_ACCEPT: begin
        if (mem_ready && wd_cnt == CW'(2)) begin
          state_nx = S_DONE;
        end else if (wd_hit) begin
          state_nx = S_DONE;
          wd_fire  = 1'b1;
        end else if (!mem_ready) begin
          state_nx = S_BUSY;
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          state_nx = S_DONE;
        end else if (wd_hit) begin
          state_nx = S_DONE;
          wd_fire  = 1'b1;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NUM_PORTS; i++) owner_oh[i] = (owner == PW'(i));
    port_grant  = (state == S_ACCEPT || state == S_BUSY) ? owner_oh : '0;
    port_done   = (state == S_DONE) ? owner_oh : '0;
    mem_execute = (state == S_ACCEPT) && (wd_cnt == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner          <= '0;
      rr_ptr         <= '0;
      wd_cnt         <= '0;
      mem_func       <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      port_read_data <= '0;
      timeout        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (state_nx == S_ACCEPT) begin
            owner          <= win;
            mem_func       <= sel_func;
            mem_address    <= sel_addr;
            mem_write_data <= sel_wdata;
            wd_cnt         <= '0;
          end
        end
        S_ACCEPT, S_BUSY: begin
          wd_cnt <= wd_cnt + CW'(1);
          if (state_nx == S_DONE) port_read_data <= wd_fire ? '0 : read_data;
          if (wd_fire) timeout <= 1'b1;
        end
        S_DONE: begin
          mem_func       <= '0;
          mem_address    <= '0;
          mem_write_data <= '0;
          rr_ptr         <= (owner == PW'(NUM_PORTS - 1)) ? '0 : owner + PW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
